// File: rtl/mac8_commit_pkg.sv
// Shared types and default sizing for the mac8 result/commit path.
package mac8_commit_pkg;

    localparam int unsigned MAC8_DEPTH = 4;
    localparam int unsigned MAC8_ID_W  = 3;
    localparam int unsigned MAC8_ACC_W = 32;

    typedef enum logic {
        MAC8_INIT = 1'b0,
        MAC8_ACC  = 1'b1
    } mac8_op_e;

    typedef struct packed {
        logic [MAC8_ID_W-1:0]  id;
        logic [MAC8_ACC_W-1:0] value;
    } mac8_entry_t;

endpackage

// File: rtl/mac8_pending_fifo.sv
// Ring of issued-but-uncommitted entries. Pointers carry a wrap bit so that
// full and empty are distinguishable without a separate counter.
module mac8_pending_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 35
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             data_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, wr_d;
    logic [PW:0]  rd_q, rd_d;

    // Next pointer values; flush wins over push and pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) begin
                wr_d = wr_q + (PW+1)'(1);
            end else begin
                wr_d = wr_q;
            end
            if (pop_i) begin
                rd_d = rd_q + (PW+1)'(1);
            end else begin
                rd_d = rd_q;
            end
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push_i && !flush_i) begin
                mem_q[wr_q[PW-1:0]] <= data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_q[PW-1:0]];
    assign count_o = wr_q - rd_q;
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);

endmodule

// File: rtl/mac8_acc_commit.sv
// mac8 result receiver: speculative accumulator forwarded to the FU,
// architectural accumulator updated on in-order commit, flush recovery.
module mac8_acc_commit
    import mac8_commit_pkg::*;
#(
    parameter int unsigned DEPTH         = MAC8_DEPTH,
    parameter int unsigned TRANS_ID_BITS = MAC8_ID_W,
    parameter int unsigned ACC_W         = MAC8_ACC_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       mac_valid_i,
    output logic                       mac_ready_o,
    input  logic                       mac_op_i,
    input  logic [ACC_W-1:0]           mac_operand_i,
    input  logic [TRANS_ID_BITS-1:0]   mac_trans_id_i,
    output logic [ACC_W-1:0]           acc_spec_o,
    output logic [ACC_W-1:0]           acc_arch_o,
    output logic                       wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [ACC_W-1:0]           wb_result_o,
    input  logic                       commit_valid_i,
    input  logic [TRANS_ID_BITS-1:0]   commit_id_i,
    output logic                       commit_err_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned EW = TRANS_ID_BITS + ACC_W;

    logic                     full_s;
    logic [EW-1:0]            head_s;
    logic [TRANS_ID_BITS-1:0] head_id_s;
    logic [ACC_W-1:0]         head_val_s;
    logic                     accept_s;
    logic                     commit_ok_s;
    logic [ACC_W-1:0]         new_acc_s;
    logic [ACC_W-1:0]         arch_post_s;

    logic [ACC_W-1:0]         acc_spec_q, acc_spec_d;
    logic [ACC_W-1:0]         acc_arch_q, acc_arch_d;
    logic                     wb_valid_q, wb_valid_d;
    logic [TRANS_ID_BITS-1:0] wb_id_q, wb_id_d;
    logic [ACC_W-1:0]         wb_result_q, wb_result_d;
    logic                     commit_err_q, commit_err_d;

    assign head_id_s   = head_s[EW-1:ACC_W];
    assign head_val_s  = head_s[ACC_W-1:0];
    // A commit this cycle does not free a slot until next cycle.
    assign mac_ready_o = ~full_s & rst_ni;

    mac8_pending_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept_s),
        .pop_i   (commit_ok_s),
        .flush_i (flush_i),
        .data_i  ({mac_trans_id_i, new_acc_s}),
        .head_o  (head_s),
        .count_o (count_o),
        .full_o  (full_s)
    );

    // Accept/commit decode, accumulator update and flush recovery.
    always_comb begin
        accept_s     = mac_valid_i & mac_ready_o & ~flush_i;
        commit_ok_s  = commit_valid_i && (count_o != '0) && (head_id_s == commit_id_i);
        new_acc_s    = (mac8_op_e'(mac_op_i) == MAC8_INIT) ? mac_operand_i
                                                           : acc_spec_q + mac_operand_i;
        arch_post_s  = commit_ok_s ? head_val_s : acc_arch_q;
        acc_arch_d   = arch_post_s;
        acc_spec_d   = acc_spec_q;
        wb_valid_d   = accept_s;
        wb_id_d      = wb_id_q;
        wb_result_d  = wb_result_q;
        commit_err_d = commit_valid_i & ~commit_ok_s;
        if (flush_i) begin
            acc_spec_d = arch_post_s;
        end else if (accept_s) begin
            acc_spec_d = new_acc_s;
        end else begin
            acc_spec_d = acc_spec_q;
        end
        if (accept_s) begin
            wb_id_d     = mac_trans_id_i;
            wb_result_d = new_acc_s;
        end else begin
            wb_id_d     = wb_id_q;
            wb_result_d = wb_result_q;
        end
    end

    // Accumulator and writeback registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_spec_q   <= '0;
            acc_arch_q   <= '0;
            wb_valid_q   <= 1'b0;
            wb_id_q      <= '0;
            wb_result_q  <= '0;
            commit_err_q <= 1'b0;
        end else begin
            acc_spec_q   <= acc_spec_d;
            acc_arch_q   <= acc_arch_d;
            wb_valid_q   <= wb_valid_d;
            wb_id_q      <= wb_id_d;
            wb_result_q  <= wb_result_d;
            commit_err_q <= commit_err_d;
        end
    end

    assign acc_spec_o    = acc_spec_q;
    assign acc_arch_o    = acc_arch_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_trans_id_o = wb_id_q;
    assign wb_result_o   = wb_result_q;
    assign commit_err_o  = commit_err_q;

endmodule

// File: tb/tb_mac8_acc_commit.sv
// Directed vector table for the mac8 commit scenarios, then randomized
// traffic checked against a queue-based reference model.
module tb_mac8_acc_commit;
    import mac8_commit_pkg::*;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        valid;
        logic        op;
        logic [31:0] operand;
        logic [2:0]  id;
        logic        cv;
        logic [2:0]  cid;
        logic        e_wbv;
        logic [2:0]  e_wbid;
        logic [31:0] e_wbres;
        logic [31:0] e_spec;
        logic [31:0] e_arch;
        logic [2:0]  e_cnt;
        logic        e_err;
        logic        e_rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        mvalid = 1'b0;
    logic        mready;
    logic        mop = 1'b0;
    logic [31:0] moperand = 32'd0;
    logic [2:0]  mid = 3'd0;
    logic [31:0] acc_spec, acc_arch;
    logic        wb_valid;
    logic [2:0]  wb_id;
    logic [31:0] wb_result;
    logic        cv = 1'b0;
    logic [2:0]  cid = 3'd0;
    logic        cerr;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    mac8_entry_t mq[$];
    logic [31:0] m_spec = 32'd0, m_arch = 32'd0, m_wbres = 32'd0;
    logic        m_wbv = 1'b0, m_err = 1'b0, m_rdy = 1'b0;
    logic [2:0]  m_wbid = 3'd0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    mac8_acc_commit dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .mac_valid_i    (mvalid),
        .mac_ready_o    (mready),
        .mac_op_i       (mop),
        .mac_operand_i  (moperand),
        .mac_trans_id_i (mid),
        .acc_spec_o     (acc_spec),
        .acc_arch_o     (acc_arch),
        .wb_valid_o     (wb_valid),
        .wb_trans_id_o  (wb_id),
        .wb_result_o    (wb_result),
        .commit_valid_i (cv),
        .commit_id_i    (cid),
        .commit_err_o   (cerr),
        .count_o        (count)
    );

    function automatic vec_t mkv(logic rst, logic fl, logic va, logic op, logic [31:0] opd,
                                 logic [2:0] id, logic c, logic [2:0] ci, logic wbv,
                                 logic [2:0] wbid, logic [31:0] wbres, logic [31:0] sp,
                                 logic [31:0] ar, logic [2:0] cn, logic er, logic rd);
        vec_t v;
        v.rst = rst; v.flush = fl; v.valid = va; v.op = op; v.operand = opd; v.id = id;
        v.cv = c; v.cid = ci; v.e_wbv = wbv; v.e_wbid = wbid; v.e_wbres = wbres;
        v.e_spec = sp; v.e_arch = ar; v.e_cnt = cn; v.e_err = er; v.e_rdy = rd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Reference model: one clock edge computed from the behavioural rules.
    task automatic model_step(input vec_t v);
        logic        accept, ok;
        logic [31:0] nv;
        if (!v.rst) begin
            mq.delete();
            m_spec = 32'd0; m_arch = 32'd0; m_wbv = 1'b0; m_wbid = 3'd0;
            m_wbres = 32'd0; m_err = 1'b0;
        end else begin
            accept = v.valid && (mq.size() < 4) && !v.flush;
            ok     = v.cv && (mq.size() > 0) && (mq[0].id == v.cid);
            nv     = v.op ? m_spec + v.operand : v.operand;
            m_err  = v.cv && !ok;
            if (ok) begin
                m_arch = mq[0].value;
                void'(mq.pop_front());
            end
            if (v.flush) begin
                mq.delete();
                m_spec = m_arch;
            end else if (accept) begin
                mq.push_back('{id: v.id, value: nv});
                m_spec = nv;
            end
            m_wbv = accept;
            if (accept) begin
                m_wbid  = v.id;
                m_wbres = nv;
            end
        end
        m_rdy = v.rst && (mq.size() < 4);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_n = v.rst; flush = v.flush; mvalid = v.valid; mop = v.op;
        moperand = v.operand; mid = v.id; cv = v.cv; cid = v.cid;
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // rst flush valid op operand id | cv cid | wbv wbid wbres spec arch cnt err rdy
        tbl.push_back(mkv(0,0,0,0,32'd0,0, 0,0, 0,0,32'd0,32'd0,32'd0,0,0,0));
        tbl.push_back(mkv(1,0,1,0,32'd5,1, 0,0, 1,1,32'd5,32'd5,32'd0,1,0,1));
        tbl.push_back(mkv(1,0,1,1,32'd3,2, 0,0, 1,2,32'd8,32'd8,32'd0,2,0,1));
        tbl.push_back(mkv(1,0,1,1,32'hFFFFFFF6,3, 0,0, 1,3,32'hFFFFFFFE,32'hFFFFFFFE,32'd0,3,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,1, 0,0,32'd0,32'hFFFFFFFE,32'd5,2,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,2, 0,0,32'd0,32'hFFFFFFFE,32'd8,1,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,3, 0,0,32'd0,32'hFFFFFFFE,32'hFFFFFFFE,0,0,1));
        tbl.push_back(mkv(1,0,1,0,32'd1,0, 0,0, 1,0,32'd1,32'd1,32'hFFFFFFFE,1,0,1));
        tbl.push_back(mkv(1,0,1,1,32'd1,1, 0,0, 1,1,32'd2,32'd2,32'hFFFFFFFE,2,0,1));
        tbl.push_back(mkv(1,0,1,1,32'd1,2, 0,0, 1,2,32'd3,32'd3,32'hFFFFFFFE,3,0,1));
        tbl.push_back(mkv(1,0,1,1,32'd1,3, 0,0, 1,3,32'd4,32'd4,32'hFFFFFFFE,4,0,0));
        tbl.push_back(mkv(1,0,1,1,32'd1,4, 0,0, 0,0,32'd0,32'd4,32'hFFFFFFFE,4,0,0));
        tbl.push_back(mkv(1,0,1,1,32'd1,5, 1,0, 0,0,32'd0,32'd4,32'd1,3,0,1));
        tbl.push_back(mkv(1,0,1,1,32'd1,5, 1,1, 1,5,32'd5,32'd5,32'd2,3,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,2, 0,0,32'd0,32'd5,32'd3,2,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,3, 0,0,32'd0,32'd5,32'd4,1,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,5, 0,0,32'd0,32'd5,32'd5,0,0,1));
        tbl.push_back(mkv(1,0,1,0,32'h7FFFFFFF,6, 0,0, 1,6,32'h7FFFFFFF,32'h7FFFFFFF,32'd5,1,0,1));
        tbl.push_back(mkv(1,0,1,1,32'd1,7, 0,0, 1,7,32'h80000000,32'h80000000,32'd5,2,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,3, 0,0,32'd0,32'h80000000,32'd5,2,1,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,6, 0,0,32'd0,32'h80000000,32'h7FFFFFFF,1,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,7, 0,0,32'd0,32'h80000000,32'h80000000,0,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,0, 0,0,32'd0,32'h80000000,32'h80000000,0,1,1));
        tbl.push_back(mkv(1,0,1,0,32'd7,0, 0,0, 1,0,32'd7,32'd7,32'h80000000,1,0,1));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 1,0, 0,0,32'd0,32'd7,32'd7,0,0,1));
        tbl.push_back(mkv(1,0,1,0,32'd9,1, 0,0, 1,1,32'd9,32'd9,32'd7,1,0,1));
        tbl.push_back(mkv(1,0,1,1,32'd1,2, 0,0, 1,2,32'd10,32'd10,32'd7,2,0,1));
        tbl.push_back(mkv(1,0,1,1,32'd1,3, 0,0, 1,3,32'd11,32'd11,32'd7,3,0,1));
        tbl.push_back(mkv(1,1,1,0,32'd100,4, 1,1, 0,0,32'd0,32'd9,32'd9,0,0,1));
        tbl.push_back(mkv(1,0,1,0,32'd1,5, 0,0, 1,5,32'd1,32'd1,32'd9,1,0,1));
        tbl.push_back(mkv(1,0,1,1,32'd1,6, 0,0, 1,6,32'd2,32'd2,32'd9,2,0,1));
        tbl.push_back(mkv(0,0,1,1,32'd1,7, 1,5, 0,0,32'd0,32'd0,32'd0,0,0,0));
        tbl.push_back(mkv(1,0,0,0,32'd0,0, 0,0, 0,0,32'd0,32'd0,32'd0,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            chk("wb_valid", i, 32'(wb_valid), 32'(tbl[i].e_wbv));
            if (tbl[i].e_wbv) begin
                chk("wb_trans_id", i, 32'(wb_id), 32'(tbl[i].e_wbid));
                chk("wb_result", i, wb_result, tbl[i].e_wbres);
            end
            chk("acc_spec", i, acc_spec, tbl[i].e_spec);
            chk("acc_arch", i, acc_arch, tbl[i].e_arch);
            chk("count", i, 32'(count), 32'(tbl[i].e_cnt));
            chk("commit_err", i, 32'(cerr), 32'(tbl[i].e_err));
            chk("mac_ready", i, 32'(mready), 32'(tbl[i].e_rdy));
        end

        for (int i = 0; i < 1500; i++) begin
            v = mkv(1,0,0,0,32'd0,0, 0,0, 0,0,32'd0,32'd0,32'd0,0,0,0);
            v.rst     = ($urandom_range(0, 99) >= 2);
            v.flush   = ($urandom_range(0, 99) < 5);
            v.valid   = ($urandom_range(0, 99) < 70);
            v.op      = ($urandom_range(0, 99) >= 25);
            v.operand = $urandom;
            v.id      = 3'($urandom_range(0, 7));
            v.cv      = ($urandom_range(0, 99) < 40);
            if (mq.size() > 0 && $urandom_range(0, 99) < 80) begin
                v.cid = mq[0].id;
            end else begin
                v.cid = 3'($urandom_range(0, 7));
            end
            apply(v);
            chk("rnd_wb_valid", i, 32'(wb_valid), 32'(m_wbv));
            if (m_wbv) begin
                chk("rnd_wb_trans_id", i, 32'(wb_id), 32'(m_wbid));
                chk("rnd_wb_result", i, wb_result, m_wbres);
            end
            chk("rnd_acc_spec", i, acc_spec, m_spec);
            chk("rnd_acc_arch", i, acc_arch, m_arch);
            chk("rnd_count", i, 32'(count), 32'(mq.size()));
            chk("rnd_commit_err", i, 32'(cerr), 32'(m_err));
            chk("rnd_mac_ready", i, 32'(mready), 32'(m_rdy));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
